// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin arbiter in front of a single-cycle
// 64-bit ALU (add, sub, and, xor). One operation is accepted per transaction
// and its result is held on rsp_* until the consumer takes it.
//
// Optional feature: define ALU_CC_EN to build in the {ZF, SF, OF}
// condition-code register and the cc output port. Without it, req_setcc is
// ignored and everything else behaves identically.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [3:0]  req_ifun0,
  input  logic [3:0]  req_ifun1,
  input  logic [63:0] req_a0,
  input  logic [63:0] req_b0,
  input  logic [63:0] req_a1,
  input  logic [63:0] req_b1,
  input  logic [1:0]  req_setcc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_result,
  output logic        rsp_err
`ifdef ALU_CC_EN
  ,
  output logic [2:0]  cc
`endif
);

  // Op codes; any value above OP_XOR is an illegal operation.
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;

  // IDLE: nothing held, may grant. HOLD: result presented on rsp_*.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state;
  logic        last_grant;   // requester granted most recently

  logic        grant_en;
  logic        grant_id;

  logic [3:0]  sel_ifun;
  logic [63:0] sel_a;
  logic [63:0] sel_b;

  logic [63:0] alu_result;
  logic        alu_err;
  logic        alu_of;

  // Arbitration: a lone requester always wins; on conflict the requester
  // that was not granted last wins. Nothing is granted in HOLD or reset.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the if/case leaves it unassigned and infers a latch.
    grant_en = 1'b0;
    grant_id = 1'b0;
    if (!rst && state == IDLE && req_valid != 2'b00) begin
      grant_en = 1'b1;
      if (req_valid == 2'b11) begin
        grant_id = ~last_grant;
      end else begin
        grant_id = req_valid[1];
      end
    end
  end

  // The accept strobe is combinational so a requester sees it in the same
  // cycle it is granted; it is one-hot or zero by construction.
  assign req_ready = {grant_en & grant_id, grant_en & ~grant_id};

  // Route the granted requester's operands into the shared ALU.
  always_comb begin
    sel_ifun = req_ifun0;
    sel_a    = req_a0;
    sel_b    = req_b0;
    if (grant_id) begin
      sel_ifun = req_ifun1;
      sel_a    = req_a1;
      sel_b    = req_b1;
    end
  end

  // ALU datapath: result modulo 2^64, plus the signed-overflow flag.
  // Subtraction is b - a, so its overflow is judged against b's sign.
  always_comb begin
    alu_result = '0;
    alu_err    = 1'b0;
    alu_of     = 1'b0;
    case (sel_ifun)
      OP_ADD: begin
        alu_result = sel_a + sel_b;
        alu_of     = (sel_a[63] == sel_b[63]) && (alu_result[63] != sel_a[63]);
      end
      OP_SUB: begin
        alu_result = sel_b - sel_a;
        alu_of     = (sel_a[63] != sel_b[63]) && (alu_result[63] != sel_b[63]);
      end
      OP_AND: begin
        alu_result = sel_a & sel_b;
      end
      OP_XOR: begin
        alu_result = sel_a ^ sel_b;
      end
      default: begin
        // Illegal op is still accepted; it returns zero flagged as an error.
        alu_err = 1'b1;
      end
    endcase
  end

  // Transaction FSM with registered response outputs and grant pointer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state      <= IDLE;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (grant_en) begin
            state      <= HOLD;
            rsp_valid  <= 1'b1;
            rsp_id     <= grant_id;
            rsp_result <= alu_result;
            rsp_err    <= alu_err;
            last_grant <= grant_id;
          end
        end
        HOLD: begin
          // Release only; a new grant waits for the following IDLE cycle.
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_CC_EN
  logic sel_setcc;

  assign sel_setcc = grant_id ? req_setcc[1] : req_setcc[0];

  // Condition codes follow a granted legal op that asked for an update;
  // illegal ops leave them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      cc <= 3'b000;
    end else if (grant_en && sel_setcc && !alu_err) begin
      cc <= {(alu_result == 64'd0), alu_result[63], alu_of};
    end
  end
`else
  // Without condition codes the update request and overflow flag have no sink.
  logic unused_cc_inputs;
  assign unused_cc_inputs = ^{req_setcc, alu_of};
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter. The stimulus process
// predicts each grant from a behavioural model and queues the expected
// response; an independent monitor pops and compares whenever a response
// appears, and re-checks it every cycle while it is held.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_ifun0;
  logic [3:0]  req_ifun1;
  logic [63:0] req_a0;
  logic [63:0] req_b0;
  logic [63:0] req_a1;
  logic [63:0] req_b1;
  logic [1:0]  req_setcc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [63:0] rsp_result;
  logic        rsp_err;
`ifdef ALU_CC_EN
  logic [2:0]  cc;
`endif

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ifun0  (req_ifun0),
    .req_ifun1  (req_ifun1),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .req_setcc  (req_setcc),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err)
`ifdef ALU_CC_EN
    ,
    .cc         (cc)
`endif
  );

  typedef struct {
    logic        id;
    logic [63:0] result;
    logic        err;
    logic [2:0]  cc;
    int          stamp;
  } rsp_t;

  rsp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state: busy = a response is outstanding.
  bit       m_busy  = 1'b0;
  int       m_last  = 1;
  logic [2:0] m_cc  = 3'b000;
  bit       granted[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Exact-arithmetic reference: overflow means the true signed value does
  // not fit in 64 bits.
  function automatic void ref_op(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] r, output logic err, output logic [2:0] flags);
    logic signed [64:0] wide;
    logic ov;
    r = '0; err = 1'b0; ov = 1'b0; wide = '0;
    if (f > 4'd3) begin
      err = 1'b1;
    end else begin
      case (f)
        4'd0: begin
          wide = $signed({a[63], a}) + $signed({b[63], b});
          r = wide[63:0];
          ov = (wide[64] != wide[63]);
        end
        4'd1: begin
          wide = $signed({b[63], b}) - $signed({a[63], a});
          r = wide[63:0];
          ov = (wide[64] != wide[63]);
        end
        4'd2: r = a & b;
        default: r = a ^ b;
      endcase
    end
    flags = {(r == 64'd0), r[63], ov};
  endfunction

  function automatic logic [63:0] rand64();
    logic [63:0] v;
    case ($urandom_range(0, 4))
      0: v = 64'h8000_0000_0000_0000;
      1: v = '1;
      2: v = 64'($urandom_range(0, 3));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  function automatic logic [3:0] rand_ifun();
    if ($urandom_range(0, 7) == 0) return 4'($urandom_range(4, 15));
    return 4'($urandom_range(0, 3));
  endfunction

  task automatic new_req(input int i);
    if (i == 0) begin
      req_ifun0 = rand_ifun(); req_a0 = rand64(); req_b0 = rand64();
    end else begin
      req_ifun1 = rand_ifun(); req_a1 = rand64(); req_b1 = rand64();
    end
    req_setcc[i] = 1'($urandom_range(0, 1));
  endtask

  // One cycle: at the falling edge predict the grant, check req_ready, queue
  // the expected response and advance the model; return #1 after the next
  // rising edge, where the caller drives the following cycle's inputs.
  task automatic step();
    logic [1:0]  exp_ready;
    logic [63:0] r;
    logic        err;
    logic [2:0]  fl;
    int          g;
    rsp_t        e;
    @(negedge clk);
    exp_ready = 2'b00;
    granted[0] = 1'b0;
    granted[1] = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_last = 1; m_cc = 3'b000;
    end else if (m_busy) begin
      if (rsp_ready) m_busy = 1'b0;
    end else if (req_valid != 2'b00) begin
      if (req_valid == 2'b11) g = 1 - m_last;
      else g = req_valid[1] ? 1 : 0;
      exp_ready[g] = 1'b1;
      if (g == 1) ref_op(req_ifun1, req_a1, req_b1, r, err, fl);
      else ref_op(req_ifun0, req_a0, req_b0, r, err, fl);
      if (!err && req_setcc[g]) m_cc = fl;
      e.id = 1'(g); e.result = r; e.err = err; e.cc = m_cc; e.stamp = cyc;
      sb.push_back(e);
      m_busy = 1'b1; m_last = g; granted[g] = 1'b1;
    end
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    @(posedge clk);
    #1;
  endtask

  // Monitor: new response on rsp_valid rising; stability while held.
  initial begin : monitor
    rsp_t cur;
    bit   holding;
    holding = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (!holding) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL rsp_unexpected: got response id=%0d result=0x%0h, expected none (cycle %0d)",
                     rsp_id, rsp_result, cyc);
            cur.id = rsp_id; cur.result = rsp_result; cur.err = rsp_err;
          end else begin
            cur = sb.pop_front();
            check("rsp_latency", 64'(cyc), 64'(cur.stamp + 1));
            check("rsp_id", 64'(rsp_id), 64'(cur.id));
            check("rsp_result", rsp_result, cur.result);
            check("rsp_err", 64'(rsp_err), 64'(cur.err));
`ifdef ALU_CC_EN
            check("cc", 64'(cc), 64'(cur.cc));
`endif
          end
          holding = 1'b1;
        end else begin
          check("hold_result", rsp_result, cur.result);
          check("hold_id_err", 64'({rsp_id, rsp_err}), 64'({cur.id, cur.err}));
        end
        if (rsp_ready) holding = 1'b0;
      end else begin
        holding = 1'b0;
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1; req_setcc = 2'b11;
    req_ifun0 = 4'd0; req_a0 = 64'd7; req_b0 = 64'd9;
    req_ifun1 = 4'd1; req_a1 = 64'd3; req_b1 = 64'd4;
    granted[0] = 1'b0; granted[1] = 1'b0;

    // Reset dominates: no grant, all outputs at reset values.
    step(); step();
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_id", 64'(rsp_id), 64'd0);
    check("reset_rsp_result", rsp_result, 64'd0);
    check("reset_rsp_err", 64'(rsp_err), 64'd0);
`ifdef ALU_CC_EN
    check("reset_cc", 64'(cc), 64'd0);
`endif

    // Lone requester 0: all-ones + 1 wraps to zero.
    rst = 1'b0; req_valid = 2'b01; req_ifun0 = 4'd0; req_a0 = '1; req_b0 = 64'd1;
    req_setcc = 2'b01; rsp_ready = 1'b0;
    step();
    req_valid = 2'b00;
    check("wrap_valid", 64'(rsp_valid), 64'd1);
    check("wrap_result", rsp_result, 64'd0);
`ifdef ALU_CC_EN
    check("wrap_cc", 64'(cc), 64'b100);
`endif
    rsp_ready = 1'b1;
    step();

    // Conflict right after reset: requester 0 first, then requester 1.
    rst = 1'b1; step(); rst = 1'b0;
    req_valid = 2'b11; req_setcc = 2'b11; rsp_ready = 1'b0;
    req_ifun0 = 4'd3; req_a0 = 64'hD3; req_b0 = 64'hD3;
    req_ifun1 = 4'd1; req_a1 = 64'd5; req_b1 = 64'd3;
    step();
    check("conflict_first_id", 64'(rsp_id), 64'd0);
    check("conflict_first_result", rsp_result, 64'd0);
    req_valid = 2'b10; rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    step();
    check("conflict_second_id", 64'(rsp_id), 64'd1);
    check("conflict_second_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFE);
`ifdef ALU_CC_EN
    check("conflict_second_cc", 64'(cc), 64'b010);
`endif
    req_valid = 2'b00; rsp_ready = 1'b1;
    step();

    // Subtract overflow: b - a = 0x8000.. - 1.
    req_valid = 2'b01; req_ifun0 = 4'd1; req_a0 = 64'd1; req_b0 = 64'h8000_0000_0000_0000;
    req_setcc = 2'b01; rsp_ready = 1'b0;
    step();
    check("subov_result", rsp_result, 64'h7FFF_FFFF_FFFF_FFFF);
`ifdef ALU_CC_EN
    check("subov_cc", 64'(cc), 64'b001);
`endif

    // Backpressure for five cycles with both requesters asking.
    req_valid = 2'b11; req_ifun0 = 4'd2; req_ifun1 = 4'd0;
    repeat (5) step();
    check("backpressure_result", rsp_result, 64'h7FFF_FFFF_FFFF_FFFF);
    req_valid = 2'b00; rsp_ready = 1'b1;
    step();

    // Illegal op: zero result, error flag, condition codes untouched.
    req_valid = 2'b10; req_ifun1 = 4'd7; req_a1 = 64'h1234; req_b1 = 64'h5678;
    req_setcc = 2'b10; rsp_ready = 1'b0;
    step();
    req_valid = 2'b00;
    check("illegal_err", 64'(rsp_err), 64'd1);
    check("illegal_result", rsp_result, 64'd0);
`ifdef ALU_CC_EN
    check("illegal_cc", 64'(cc), 64'b001);
`endif

    // Reset while holding discards the result.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("hold_reset_valid", 64'(rsp_valid), 64'd0);
    check("hold_reset_id", 64'(rsp_id), 64'd0);
    check("hold_reset_result", rsp_result, 64'd0);
    check("hold_reset_err", 64'(rsp_err), 64'd0);
`ifdef ALU_CC_EN
    check("hold_reset_cc", 64'(cc), 64'd0);
`endif

    // Randomised traffic: requests stay stable until accepted, with
    // occasional withdrawals, random backpressure and sporadic resets.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 2; i++) begin
        if (granted[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          if (req_valid[i]) new_req(i);
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    // Drain and confirm every predicted response was observed.
    rst = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
    repeat (4) step();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
